// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped timer/compare peripheral:
// register word indices, CTRL bit positions and the bus FSM state type.
package timer_pkg;

   localparam logic [1:0] REG_CTRL     = 2'd0;
   localparam logic [1:0] REG_PRESCALE = 2'd1;
   localparam logic [1:0] REG_COUNT    = 2'd2;
   localparam logic [1:0] REG_COMPARE  = 2'd3;

   localparam int CTRL_EN       = 0;
   localparam int CTRL_IRQ_EN   = 1;
   localparam int CTRL_PENDING  = 2;
   localparam int CTRL_PERIODIC = 3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } bus_state_e;

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler down-counter: emits a one-cycle tick when it reaches zero,
// then reloads. Held at the reload value while disabled.
module timer_prescaler #(
   parameter int PRESCALE_W = 16
) (
   input  logic                  i_clock,
   input  logic                  i_reset_n,
   input  logic                  i_enable,
   input  logic [PRESCALE_W-1:0] i_reload_value,
   input  logic                  i_reload,
   output logic                  o_tick
);

   logic [PRESCALE_W-1:0] cnt_q;
   logic [PRESCALE_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q - 1'b1;
      if (!i_enable || i_reload || (cnt_q == '0)) begin
         cnt_d = i_reload_value;
      end
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign o_tick = i_enable && (cnt_q == '0);

endmodule

// File: rtl/timer.sv
// Memory-mapped 32-bit timer/compare peripheral with a request/ready bus
// responder, prescaled free-running counter and registered level interrupt.
//
//   state  | meaning
//   IDLE   | waiting for i_request
//   ACCESS | write commits / read data latched
//   DONE   | o_ready high until i_request falls
module timer
   import timer_pkg::*;
#(
   parameter int PRESCALE_W = 16
) (
   input  logic        i_clock,
   input  logic        i_reset_n,
   input  logic        i_request,
   input  logic        i_rw,
   input  logic [3:0]  i_address,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_rdata,
   output logic        o_ready,
   output logic        o_interrupt
);

   bus_state_e state_q;
   logic [31:0] rdata_q;
   logic        ready_q;
   logic        irq_q;

   logic en_q, en_d;
   logic irq_en_q, irq_en_d;
   logic pending_q, pending_d;
   logic periodic_q, periodic_d;
   logic [PRESCALE_W-1:0] prescale_q, prescale_d;
   logic [31:0] count_q, count_d;
   logic [31:0] compare_q, compare_d;

   logic [1:0]  word;
   logic        wr_en, wr_ctrl, wr_prescale, wr_count, wr_compare;
   logic        tick, match;
   logic [PRESCALE_W-1:0] reload_value;
   logic [31:0] rd_val;
   logic        addr_unused;

   assign word        = i_address[3:2];
   assign addr_unused = ^i_address[1:0];

   assign wr_en       = (state_q == ACCESS) && i_rw;
   assign wr_ctrl     = wr_en && (word == REG_CTRL);
   assign wr_prescale = wr_en && (word == REG_PRESCALE);
   assign wr_count    = wr_en && (word == REG_COUNT);
   assign wr_compare  = wr_en && (word == REG_COMPARE);

   // Load the value being written so the new period starts immediately.
   assign reload_value = wr_prescale ? i_wdata[PRESCALE_W-1:0] : prescale_q;

   timer_prescaler #(
      .PRESCALE_W(PRESCALE_W)
   ) u_prescaler (
      .i_clock       (i_clock),
      .i_reset_n     (i_reset_n),
      .i_enable      (en_q),
      .i_reload_value(reload_value),
      .i_reload      (wr_prescale || wr_count),
      .o_tick        (tick)
   );

   assign match = tick && (count_q == compare_q);

   always_comb begin
      rd_val = '0;
      case (word)
         REG_CTRL: begin
            rd_val[CTRL_EN]       = en_q;
            rd_val[CTRL_IRQ_EN]   = irq_en_q;
            rd_val[CTRL_PENDING]  = pending_q;
            rd_val[CTRL_PERIODIC] = periodic_q;
         end
         REG_PRESCALE: rd_val[PRESCALE_W-1:0] = prescale_q;
         REG_COUNT:    rd_val = count_q;
         default:      rd_val = compare_q;
      endcase
   end

   always_comb begin
      en_d       = en_q;
      irq_en_d   = irq_en_q;
      pending_d  = pending_q;
      periodic_d = periodic_q;
      prescale_d = prescale_q;
      count_d    = count_q;
      compare_d  = compare_q;

      if (wr_ctrl) begin
         en_d       = i_wdata[CTRL_EN];
         irq_en_d   = i_wdata[CTRL_IRQ_EN];
         periodic_d = i_wdata[CTRL_PERIODIC];
         if (i_wdata[CTRL_PENDING]) begin
            pending_d = 1'b0;
         end
      end
      // A match beats a simultaneous write-1-to-clear.
      if (match) begin
         pending_d = 1'b1;
      end

      if (wr_prescale) begin
         prescale_d = i_wdata[PRESCALE_W-1:0];
      end
      if (wr_compare) begin
         compare_d = i_wdata;
      end

      if (wr_count) begin
         count_d = i_wdata;
      end else if (tick) begin
         count_d = (match && periodic_q) ? 32'd0 : count_q + 32'd1;
      end
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         en_q       <= 1'b0;
         irq_en_q   <= 1'b0;
         pending_q  <= 1'b0;
         periodic_q <= 1'b0;
         prescale_q <= '0;
         count_q    <= '0;
         compare_q  <= '0;
         irq_q      <= 1'b0;
      end else begin
         en_q       <= en_d;
         irq_en_q   <= irq_en_d;
         pending_q  <= pending_d;
         periodic_q <= periodic_d;
         prescale_q <= prescale_d;
         count_q    <= count_d;
         compare_q  <= compare_d;
         irq_q      <= pending_q && irq_en_q;
      end
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= IDLE;
         rdata_q <= '0;
         ready_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               ready_q <= 1'b0;
               if (i_request) begin
                  state_q <= ACCESS;
               end
            end
            ACCESS: begin
               if (!i_rw) begin
                  rdata_q <= rd_val;
               end
               ready_q <= 1'b1;
               state_q <= DONE;
            end
            DONE: begin
               if (!i_request) begin
                  ready_q <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: begin
               ready_q <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign o_rdata     = rdata_q;
   assign o_ready     = ready_q;
   assign o_interrupt = irq_q;

endmodule

// File: tb/tb_timer.sv
// Directed bench for the timer peripheral: a register vector table followed
// by hand-timed sequences for counting, compare, wrap and reset corners.
module tb_timer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req = 1'b0;
   logic        rw = 1'b0;
   logic [3:0]  addr = '0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic        ready;
   logic        irq;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   logic arm = 1'b0;
   logic irq_seen = 1'b0;
   int   irq_cyc = 0;

   timer #(.PRESCALE_W(16)) dut (
      .i_clock    (clk),
      .i_reset_n  (rst_n),
      .i_request  (req),
      .i_rw       (rw),
      .i_address  (addr),
      .i_wdata    (wdata),
      .o_rdata    (rdata),
      .o_ready    (ready),
      .o_interrupt(irq)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!arm) begin
         irq_seen <= 1'b0;
      end else if (irq && !irq_seen) begin
         irq_seen <= 1'b1;
         irq_cyc  <= cyc;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   typedef struct packed {
      logic        rw;
      logic [3:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [18];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic xfer(input logic t_rw, input logic [3:0] t_addr,
                       input logic [31:0] t_wd, output logic [31:0] t_rd);
      int waited;
      waited = 0;
      @(negedge clk);
      req   = 1'b1;
      rw    = t_rw;
      addr  = t_addr;
      wdata = t_wd;
      while (!ready && waited < 8) begin
         @(negedge clk);
         waited++;
      end
      check("ready_latency", 32'(waited), 32'd2);
      t_rd = rdata;
      req  = 1'b0;
      @(negedge clk);
      check("ready_fall", {31'b0, ready}, 32'd0);
   endtask

   task automatic wr(input logic [3:0] t_addr, input logic [31:0] t_wd);
      logic [31:0] dummy;
      xfer(1'b1, t_addr, t_wd, dummy);
   endtask

   task automatic rd_chk(input string name, input logic [3:0] t_addr, input logic [31:0] exp);
      logic [31:0] v;
      xfer(1'b0, t_addr, 32'h0, v);
      check(name, v, exp);
   endtask

   initial begin
      logic [31:0] v;
      int en_cyc;
      int waited;
      logic [31:0] seq_b [6];

      vecs[0]  = '{1'b0, 4'h0, 32'h0,         32'h0};
      vecs[1]  = '{1'b0, 4'h4, 32'h0,         32'h0};
      vecs[2]  = '{1'b0, 4'h8, 32'h0,         32'h0};
      vecs[3]  = '{1'b0, 4'hC, 32'h0,         32'h0};
      vecs[4]  = '{1'b1, 4'h4, 32'h0001_2345, 32'h0};
      vecs[5]  = '{1'b0, 4'h4, 32'h0,         32'h0000_2345};
      vecs[6]  = '{1'b1, 4'h8, 32'hDEAD_BEEF, 32'h0};
      vecs[7]  = '{1'b0, 4'h8, 32'h0,         32'hDEAD_BEEF};
      vecs[8]  = '{1'b1, 4'hF, 32'hCAFE_F00D, 32'h0};
      vecs[9]  = '{1'b0, 4'hC, 32'h0,         32'hCAFE_F00D};
      vecs[10] = '{1'b1, 4'h0, 32'hFFFF_FFFA, 32'h0};
      vecs[11] = '{1'b0, 4'h1, 32'h0,         32'h0000_000A};
      vecs[12] = '{1'b1, 4'h0, 32'h0,         32'h0};
      vecs[13] = '{1'b0, 4'h0, 32'h0,         32'h0};
      vecs[14] = '{1'b1, 4'h8, 32'h0,         32'h0};
      vecs[15] = '{1'b1, 4'hC, 32'h0,         32'h0};
      vecs[16] = '{1'b1, 4'h4, 32'h0,         32'h0};
      vecs[17] = '{1'b0, 4'h9, 32'h0,         32'h0};

      seq_b[0] = 32'd0; seq_b[1] = 32'd1; seq_b[2] = 32'd2;
      seq_b[3] = 32'd0; seq_b[4] = 32'd1; seq_b[5] = 32'd2;

      // reset values
      repeat (3) @(negedge clk);
      check("reset_ready", {31'b0, ready}, 32'd0);
      check("reset_rdata", rdata, 32'd0);
      check("reset_irq", {31'b0, irq}, 32'd0);
      rst_n = 1'b1;

      // register table
      for (int i = 0; i < 18; i++) begin
         xfer(vecs[i].rw, vecs[i].addr, vecs[i].wdata, v);
         if (!vecs[i].rw) check($sformatf("vec%0d_rdata", i), v, vecs[i].exp);
      end

      // prescale 3, compare 5, one-shot with irq
      wr(4'h4, 32'd3);
      wr(4'hC, 32'd5);
      wr(4'h8, 32'd0);
      arm = 1'b1;
      wr(4'h0, 32'h3);
      en_cyc = cyc;
      for (int j = 1; j <= 7; j++) begin
         rd_chk($sformatf("presc_count%0d", j), 4'h8, 32'(j - 1));
         check($sformatf("presc_irq%0d", j), {31'b0, irq}, (j >= 6) ? 32'd1 : 32'd0);
      end
      rd_chk("presc_ctrl", 4'h0, 32'h7);
      check("irq_seen", {31'b0, irq_seen}, 32'd1);
      check("irq_latency", 32'(irq_cyc - en_cyc), 32'd24);
      arm = 1'b0;
      wr(4'h0, 32'h4);
      check("irq_clear", {31'b0, irq}, 32'd0);

      // periodic, prescale 0, compare 2
      wr(4'h8, 32'd0);
      wr(4'h4, 32'd0);
      wr(4'hC, 32'd2);
      wr(4'h0, 32'hB);
      for (int j = 0; j < 6; j++) begin
         rd_chk($sformatf("periodic_count%0d", j), 4'h8, seq_b[j]);
      end
      rd_chk("periodic_ctrl", 4'h0, 32'hF);
      wr(4'h0, 32'hD);
      rd_chk("periodic_reset", 4'h0, 32'hD);
      wr(4'h0, 32'h0);
      wr(4'h0, 32'h4);
      rd_chk("periodic_off", 4'h0, 32'h0);

      // 32-bit wrap with no false match
      wr(4'h4, 32'd3);
      wr(4'h8, 32'hFFFF_FFFE);
      wr(4'hC, 32'h10);
      wr(4'h0, 32'h1);
      rd_chk("wrap0", 4'h8, 32'hFFFF_FFFE);
      rd_chk("wrap1", 4'h8, 32'hFFFF_FFFF);
      rd_chk("wrap2", 4'h8, 32'h0000_0000);
      rd_chk("wrap3", 4'h8, 32'h0000_0001);
      rd_chk("wrap_nopend", 4'h0, 32'h1);
      repeat (60) @(negedge clk);
      rd_chk("wrap_pend", 4'h0, 32'h5);
      rd_chk("wrap_count", 4'h8, 32'h13);
      wr(4'h0, 32'h4);

      // W1C in the same cycle as a match: set wins
      wr(4'h4, 32'd0);
      wr(4'h8, 32'd0);
      wr(4'hC, 32'd3);
      wr(4'h0, 32'h3);
      wr(4'h0, 32'h7);
      check("setwins_irq_a", {31'b0, irq}, 32'd1);
      rd_chk("setwins_ctrl", 4'h0, 32'h7);
      check("setwins_irq_b", {31'b0, irq}, 32'd1);
      wr(4'h0, 32'h6);
      check("late_clear_irq", {31'b0, irq}, 32'd0);
      rd_chk("late_clear_ctrl", 4'h0, 32'h2);

      // reset while in DONE of a COMPARE write
      @(negedge clk);
      req   = 1'b1;
      rw    = 1'b1;
      addr  = 4'hC;
      wdata = 32'h55;
      waited = 0;
      while (!ready && waited < 8) begin
         @(negedge clk);
         waited++;
      end
      check("rst_done_reached", {31'b0, ready}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst_ready", {31'b0, ready}, 32'd0);
      check("rst_rdata", rdata, 32'd0);
      req = 1'b0;
      #2;
      rst_n = 1'b1;
      rd_chk("rst_compare", 4'hC, 32'h0);
      rd_chk("rst_ctrl", 4'h0, 32'h0);
      wr(4'hC, 32'h77);
      rd_chk("post_rst_compare", 4'hC, 32'h77);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
